xor_share_arbiter: RTL and testbench

- Shares one registered XOR datapath among NREQ requesters. Arbitration is round-robin.
- Each requester presents an operand pair A/B with a valid/ready handshake. The winner's A^B is registered and returned on one response channel, tagged with the winner's ID.
- Sits between the requester blocks and the shared XOR resource, and sequences all access to it.

---
 rtl/xor_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 34 +++
 rtl/xor_share_arbiter.sv | 83 ++++++++
 tb/tb_xor_share_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/xor_arb_pkg.sv
// Shared constants and helpers for the XOR share arbiter.
// State encoding and defaults live here for reuse by later controllers.
package xor_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;
  localparam int IDW_DEF  = 2;
  localparam int CNTW_DEF = 16;

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid bit at or after ptr.
// Emits a one-hot grant, its encoded index and an any-valid flag.
module rr_pick
  import xor_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = {1'b0, ptr} + (IDW+1)'(i);
      if (j >= (IDW+1)'(NREQ)) j = j - (IDW+1)'(NREQ);
      if (!any && valid[j[IDW-1:0]]) begin
        any = 1'b1;
        gnt[j[IDW-1:0]] = 1'b1;
        idx = j[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/xor_share_arbiter.sv
// One registered XOR datapath shared round-robin among NREQ requesters.
// Result slot drains and refills in the same cycle for full throughput.
module xor_share_arbiter
  import xor_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = IDW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   REQ_VALID,
  input  logic [NREQ*W-1:0] REQ_A,
  input  logic [NREQ*W-1:0] REQ_B,
  output logic [NREQ-1:0]   REQ_READY,
  output logic              RSP_VALID,
  output logic [W-1:0]      RSP_DATA,
  output logic [IDW-1:0]    RSP_ID,
  input  logic              RSP_READY,
  output logic [CNTW-1:0]   OP_COUNT,
  output logic              BUSY
);

  if (IDW < clog2(NREQ) || NREQ < 2 || NREQ > 8) begin : g_bad_cfg
    $error("xor_share_arbiter: bad NREQ/IDW");
  end

  logic            state;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  win;
  logic            any;
  logic            slot_free;
  logic            take;
  logic            hs;
  logic [IDW-1:0]  ptr_nxt;
  logic [W-1:0]    win_xor;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid (REQ_VALID),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (win),
    .any   (any)
  );

  assign hs        = (state == FULL) & RSP_READY;
  assign slot_free = (state == EMPTY) | RSP_READY;
  // RST_N gates the grant so nothing is accepted while held in reset
  assign take      = slot_free & any & RST_N;
  assign REQ_READY = take ? gnt : '0;

  assign ptr_nxt = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
  assign win_xor = REQ_A[win*W +: W] ^ REQ_B[win*W +: W];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= EMPTY;
      ptr      <= '0;
      RSP_DATA <= '0;
      RSP_ID   <= '0;
      OP_COUNT <= '0;
    end else begin
      if (take) begin
        RSP_DATA <= win_xor;
        RSP_ID   <= win;
        ptr      <= ptr_nxt;
        state    <= FULL;
      end else if (hs) begin
        state    <= EMPTY;
      end
      if (hs) OP_COUNT <= OP_COUNT + 1'b1;
    end
  end

  assign RSP_VALID = (state == FULL);
  assign BUSY      = (state == FULL) | (|REQ_VALID);

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed bench for xor_share_arbiter.
// Inputs change 1ns after the rising edge; outputs are sampled after settle.
module tb_xor_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [NREQ-1:0]   REQ_VALID;
  logic [NREQ*W-1:0] REQ_A;
  logic [NREQ*W-1:0] REQ_B;
  logic [NREQ-1:0]   REQ_READY;
  logic              RSP_VALID;
  logic [W-1:0]      RSP_DATA;
  logic [IDW-1:0]    RSP_ID;
  logic              RSP_READY;
  logic [CNTW-1:0]   OP_COUNT;
  logic              BUSY;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  xor_share_arbiter #(
    .NREQ (NREQ),
    .W    (W),
    .IDW  (IDW),
    .CNTW (CNTW)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_VALID (REQ_VALID),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .REQ_READY (REQ_READY),
    .RSP_VALID (RSP_VALID),
    .RSP_DATA  (RSP_DATA),
    .RSP_ID    (RSP_ID),
    .RSP_READY (RSP_READY),
    .OP_COUNT  (OP_COUNT),
    .BUSY      (BUSY)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input int i,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b);
    REQ_A[i*W +: W] = a;
    REQ_B[i*W +: W] = b;
  endtask

  initial begin
    RST_N     = 1'b0;
    REQ_VALID = '0;
    REQ_A     = '0;
    REQ_B     = '0;
    RSP_READY = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(RSP_VALID), 32'h0);
    chk("rst_data",  32'(RSP_DATA),  32'h0);
    chk("rst_id",    32'(RSP_ID),    32'h0);
    chk("rst_count", 32'(OP_COUNT),  32'h0);
    chk("rst_ready", 32'(REQ_READY), 32'h0);
    RST_N = 1'b1;
    tick();

    // single request from requester 2
    set_op(2, 8'hA5, 8'h0F);
    REQ_VALID = 4'b0100;
    RSP_READY = 1'b1;
    #1;
    chk("one_ready", 32'(REQ_READY), 32'h4);
    chk("one_pre_v", 32'(RSP_VALID), 32'h0);
    tick();
    REQ_VALID = '0;
    chk("one_valid", 32'(RSP_VALID), 32'h1);
    chk("one_data",  32'(RSP_DATA),  32'hAA);
    chk("one_id",    32'(RSP_ID),    32'h2);
    chk("one_cnt0",  32'(OP_COUNT),  32'h0);
    tick();
    chk("one_cnt1",  32'(OP_COUNT),  32'h1);
    chk("one_empty", 32'(RSP_VALID), 32'h0);

    // hold a result then reset asynchronously mid-cycle
    for (int i = 0; i < NREQ; i++) set_op(i, W'(i), 8'hF0);
    REQ_VALID = 4'b1111;
    RSP_READY = 1'b0;
    #1;
    chk("mid_ready", 32'(REQ_READY), 32'h8);
    tick();
    chk("mid_valid", 32'(RSP_VALID), 32'h1);
    chk("mid_id",    32'(RSP_ID),    32'h3);
    chk("mid_data",  32'(RSP_DATA),  32'hF3);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_valid", 32'(RSP_VALID), 32'h0);
    chk("arst_data",  32'(RSP_DATA),  32'h0);
    chk("arst_id",    32'(RSP_ID),    32'h0);
    chk("arst_count", 32'(OP_COUNT),  32'h0);
    chk("arst_ready", 32'(REQ_READY), 32'h0);
    tick();
    RST_N     = 1'b1;
    RSP_READY = 1'b1;
    #1;
    chk("rel_first", 32'(REQ_READY), 32'h1);

    // round robin, one result per cycle
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_valid", 32'(RSP_VALID), 32'h1);
      chk("rr_id",    32'(RSP_ID),    32'(k % 4));
      chk("rr_data",  32'(RSP_DATA),  32'(8'hF0 | 8'(k % 4)));
    end
    REQ_VALID = '0;
    tick();
    chk("rr_count", 32'(OP_COUNT),  32'd6);
    chk("rr_empty", 32'(RSP_VALID), 32'h0);

    // backpressure with result 3C from requester 1
    set_op(1, 8'hCC, 8'hF0);
    REQ_VALID = 4'b0010;
    RSP_READY = 1'b0;
    #1;
    chk("bp_load", 32'(REQ_READY), 32'h2);
    tick();
    REQ_VALID = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 32'(REQ_READY), 32'h0);
      chk("bp_data",  32'(RSP_DATA),  32'h3C);
      chk("bp_id",    32'(RSP_ID),    32'h1);
      chk("bp_busy",  32'(BUSY),      32'h1);
      tick();
    end
    RSP_READY = 1'b1;
    #1;
    chk("bp_grant3", 32'(REQ_READY), 32'h8);
    tick();
    chk("bp_id3",   32'(RSP_ID),   32'h3);
    chk("bp_data3", 32'(RSP_DATA), 32'hF3);
    chk("bp_count", 32'(OP_COUNT), 32'd7);

    // drain and refill in one cycle
    set_op(1, 8'h55, 8'h0F);
    REQ_VALID = 4'b0010;
    #1;
    chk("dr_ready", 32'(REQ_READY), 32'h2);
    tick();
    REQ_VALID = '0;
    chk("dr_valid", 32'(RSP_VALID), 32'h1);
    chk("dr_id",    32'(RSP_ID),    32'h1);
    chk("dr_data",  32'(RSP_DATA),  32'h5A);
    chk("dr_count", 32'(OP_COUNT),  32'd8);
    tick();
    chk("dr_cnt9",  32'(OP_COUNT),  32'd9);
    chk("dr_idle",  32'(BUSY),      32'h0);

    // counter wrap: 65526 more handshakes reach FFFF
    REQ_VALID = 4'b0001;
    for (int n = 0; n < 65527; n++) tick();
    chk("wrap_max",  32'(OP_COUNT), 32'hFFFF);
    tick();
    chk("wrap_zero", 32'(OP_COUNT), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
